// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared opcode, condition, ALU-op and state encodings for the ALU sequencer
package alu_ctrl_pkg;
  localparam int OPC_W = 4;
  localparam logic [OPC_W-1:0] OPC_ADD = 4'b0000;
  localparam logic [OPC_W-1:0] OPC_ADI = 4'b0001;
  localparam logic [OPC_W-1:0] OPC_NDU = 4'b0010;
  localparam logic [OPC_W-1:0] OPC_BEQ = 4'b1100;
  localparam logic [1:0] COND_NONE = 2'b00;
  localparam logic [1:0] COND_Z = 2'b01;
  localparam logic [1:0] COND_C = 2'b10;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_EQ = 2'b01;
  localparam logic [1:0] ALU_NAND = 2'b10;
  localparam logic [1:0] ALU_PASS = 2'b11;
  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_EXEC, S_WB, S_DONE} state_t;
  function automatic logic [1:0] alu_op(input logic [OPC_W-1:0] opc);
    return (opc == OPC_ADD || opc == OPC_ADI) ? ALU_ADD :
           opc == OPC_NDU ? ALU_NAND :
           opc == OPC_BEQ ? ALU_EQ : ALU_PASS;
  endfunction
endpackage

// File: rtl/alu_cond_check.sv
// alu_cond_check: opcode legality and C/Z condition gating for an instruction
module alu_cond_check
  import alu_ctrl_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  input  logic [1:0]       cond,
  input  logic             c,
  input  logic             z,
  output logic             execute,
  output logic             legal
);
  logic cond_ok;
  logic uncond;
  // ADI and BEQ ignore cond; code 11 behaves like unconditional
  always_comb begin
    legal = opcode == OPC_ADD || opcode == OPC_ADI || opcode == OPC_NDU || opcode == OPC_BEQ;
    uncond = opcode == OPC_ADI || opcode == OPC_BEQ;
    cond_ok = cond == COND_C ? c : cond == COND_Z ? z : 1'b1;
    execute = legal && (uncond || cond_ok);
  end
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: multi-cycle control FSM sequencing the ALU and owning the C/Z flags
module alu_op_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [OPC_W-1:0] opcode,
  input  logic [1:0]       cond,
  input  logic [W-1:0]     alu_result,
  input  logic [W-1:0]     alu_flags,
  output logic [1:0]       op_sel,
  output logic             aorb,
  output logic             b_imm_sel,
  output logic             rf_we,
  output logic             c_flag,
  output logic             z_flag,
  output logic             branch_taken,
  output logic             illegal,
  output logic             busy,
  output logic             done
);
  state_t state;
  logic [OPC_W-1:0] opc_q;
  logic [1:0] cond_q;
  logic [OPC_W-1:0] opc_chk;
  logic execute;
  logic legal;
  logic unused_flags;
  // in IDLE the checker looks at the incoming opcode so the illegal pulse lands in CHECK
  assign opc_chk = state == S_IDLE ? opcode : opc_q;
  assign aorb = 1'b1;
  assign unused_flags = ^alu_flags[W-1:1];
  alu_cond_check u_cond_check (
    .opcode (opc_chk),
    .cond   (cond_q),
    .c      (c_flag),
    .z      (z_flag),
    .execute(execute),
    .legal  (legal)
  );
  // sequencer FSM; every output is registered on entry to the state that shows it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      opc_q <= '0;
      cond_q <= '0;
      op_sel <= ALU_PASS;
      b_imm_sel <= 1'b0;
      rf_we <= 1'b0;
      c_flag <= 1'b0;
      z_flag <= 1'b0;
      branch_taken <= 1'b0;
      illegal <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          state <= S_CHECK;
          busy <= 1'b1;
          opc_q <= opcode;
          cond_q <= cond;
          illegal <= !legal;
        end
        S_CHECK: begin
          illegal <= 1'b0;
          if (execute) begin
            state <= S_EXEC;
            op_sel <= alu_op(opc_q);
            b_imm_sel <= opc_q == OPC_ADI;
          end else begin
            state <= S_DONE;
            done <= 1'b1;
          end
        end
        S_EXEC: begin
          state <= S_WB;
          if (opc_q == OPC_BEQ) branch_taken <= alu_result[0];
          else begin
            rf_we <= 1'b1;
            z_flag <= alu_result == '0;
            if (opc_q != OPC_NDU) c_flag <= alu_flags[0];
          end
        end
        S_WB: begin
          state <= S_DONE;
          rf_we <= 1'b0;
          branch_taken <= 1'b0;
          done <= 1'b1;
          op_sel <= ALU_PASS;
          b_imm_sel <= 1'b0;
        end
        S_DONE: begin
          state <= S_IDLE;
          done <= 1'b0;
          busy <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed and random checks of the sequencer against a cycle-count reference model
module tb_alu_op_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [3:0] opcode = '0;
  logic [1:0] cond = '0;
  logic [15:0] alu_result = '0;
  logic [15:0] alu_flags = '0;
  logic [1:0] op_sel;
  logic aorb, b_imm_sel, rf_we, c_flag, z_flag, branch_taken, illegal, busy, done;
  int nchk = 0;
  int nerr = 0;
  bit mc = 0;
  bit mz = 0;
  always #5 clk = ~clk;
  alu_op_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .cond(cond),
    .alu_result(alu_result), .alu_flags(alu_flags), .op_sel(op_sel), .aorb(aorb),
    .b_imm_sel(b_imm_sel), .rf_we(rf_we), .c_flag(c_flag), .z_flag(z_flag),
    .branch_taken(branch_taken), .illegal(illegal), .busy(busy), .done(done)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run_instr(input logic [3:0] opc, input logic [1:0] cnd, input logic [15:0] res, input logic [15:0] flg);
    bit lg, ex, ewe, ebr;
    int lat;
    int we_c = 0, br_c = 0, ill_c = 0, dn_c = 0, we_n = 0, br_n = 0, ill_n = 0;
    logic [1:0] eop;
    lg = opc == 4'd0 || opc == 4'd1 || opc == 4'd2 || opc == 4'd12;
    ex = lg && (opc == 4'd1 || opc == 4'd12 || !((cnd == 2'b10 && !mc) || (cnd == 2'b01 && !mz)));
    lat = ex ? 4 : 2;
    ewe = ex && opc != 4'd12;
    ebr = ex && opc == 4'd12 && res[0];
    eop = opc == 4'd2 ? 2'b10 : opc == 4'd12 ? 2'b01 : 2'b00;
    start = 1'b1;
    opcode = opc;
    cond = cnd;
    alu_result = res;
    alu_flags = flg;
    tick();
    start = 1'b0;
    opcode = 4'($urandom);
    cond = 2'($urandom);
    chk("busy_accept", busy, 1);
    for (int cyc = 1; cyc <= 6; cyc++) begin
      if (rf_we) begin we_n++; we_c = cyc; end
      if (branch_taken) begin br_n++; br_c = cyc; end
      if (illegal) begin ill_n++; ill_c = cyc; end
      if (ex && (cyc == 2 || cyc == 3)) chk("op_sel_exec", op_sel, eop);
      if (ex && cyc == 2) chk("b_imm_sel", b_imm_sel, opc == 4'd1);
      if (done) begin
        dn_c = cyc;
        chk("op_sel_done", op_sel, 2'b11);
      end
      tick();
      if (dn_c != 0) break;
    end
    if (ewe) begin
      mz = res == 16'h0;
      if (opc != 4'd2) mc = flg[0];
    end
    chk("done_cycle", dn_c, lat);
    chk("we_cycle", we_c, ewe ? 3 : 0);
    chk("we_count", we_n, ewe ? 1 : 0);
    chk("br_cycle", br_c, ebr ? 3 : 0);
    chk("br_count", br_n, ebr ? 1 : 0);
    chk("ill_cycle", ill_c, lg ? 0 : 1);
    chk("ill_count", ill_n, lg ? 0 : 1);
    chk("c_flag", c_flag, mc);
    chk("z_flag", z_flag, mz);
    chk("busy_idle", busy, 0);
    chk("op_sel_idle", op_sel, 2'b11);
  endtask
  initial begin
    int dn, we;
    logic [3:0] ropc;
    logic [15:0] rres;
    tick();
    tick();
    chk("rst_op_sel", op_sel, 2'b11);
    chk("rst_aorb", aorb, 1);
    chk("rst_outs", {b_imm_sel, rf_we, c_flag, z_flag, branch_taken, illegal, busy, done}, 0);
    rst_n = 1'b1;
    tick();
    run_instr(4'd0, 2'b00, 16'h0000, 16'h0001);
    start = 1'b1;
    opcode = 4'd0;
    cond = 2'b00;
    alu_result = 16'h0005;
    alu_flags = 16'h0001;
    tick();
    start = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("abort_op_sel", op_sel, 2'b11);
    chk("abort_flags", {c_flag, z_flag}, 0);
    chk("abort_we_done_busy", {rf_we, done, busy}, 0);
    mc = 0;
    mz = 0;
    tick();
    chk("abort_we_hold", rf_we, 0);
    rst_n = 1'b1;
    tick();
    run_instr(4'd0, 2'b10, 16'h1234, 16'h0001);
    run_instr(4'd0, 2'b00, 16'h0001, 16'h0001);
    run_instr(4'd0, 2'b10, 16'h0000, 16'h0000);
    run_instr(4'd0, 2'b00, 16'h0001, 16'h0001);
    run_instr(4'd2, 2'b00, 16'h00F0, 16'h0000);
    run_instr(4'd12, 2'b00, 16'h0001, 16'h0000);
    run_instr(4'd12, 2'b00, 16'h0000, 16'h0000);
    run_instr(4'd7, 2'b00, 16'h0005, 16'h0001);
    run_instr(4'd1, 2'b01, 16'h8000, 16'h0000);
    run_instr(4'd0, 2'b01, 16'h0003, 16'h0001);
    dn = 0;
    we = 0;
    start = 1'b1;
    opcode = 4'd0;
    cond = 2'b00;
    alu_result = 16'h0001;
    alu_flags = 16'h0000;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (done) dn++;
      if (rf_we) we++;
      if (done) chk("held_we_excl", rf_we, 0);
    end
    start = 1'b0;
    chk("held_done_count", dn, 4);
    chk("held_we_count", we, 4);
    mc = 0;
    mz = 0;
    tick();
    chk("held_idle_busy", busy, 0);
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 4))
        0: ropc = 4'd0;
        1: ropc = 4'd1;
        2: ropc = 4'd2;
        3: ropc = 4'd12;
        default: ropc = 4'($urandom);
      endcase
      rres = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      run_instr(ropc, 2'($urandom), rres, 16'($urandom));
    end
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
